uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_tx_arbiter_if.sv | 16 +
 rtl/uart_tx_arbiter_rr_pick.sv | 21 ++
 rtl/uart_tx_arbiter.sv | 88 ++++++++
 tb/tb_uart_tx_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and tag defaults for the UART transmit arbiter
package uart_pkg;
  localparam logic [7:0] TAG_BASE_DEF = 8'hA0;
`ifdef UART_ARB_TAG_EN
  typedef enum logic [2:0] {ST_ARB, ST_LOAD, ST_WAIT_BUSY, ST_WAIT_IDLE, ST_TAG} state_t;
`else
  typedef enum logic [1:0] {ST_ARB, ST_LOAD, ST_WAIT_BUSY, ST_WAIT_IDLE} state_t;
`endif
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte streams plus the uart_send load handshake
interface uart_tx_arbiter_if #(parameter int NREQ = 4);
  logic [8*NREQ-1:0] REQ_DATA;
  logic [NREQ-1:0]   REQ_VALID;
  logic [NREQ-1:0]   REQ_LAST;
  logic [NREQ-1:0]   REQ_ACK;
  logic [NREQ-1:0]   GRANT;
  logic [7:0]        TX_DATA;
  logic              TX_DATA_READY;
  logic              TX_IDLE;
  logic              BUSY;
  modport master (output REQ_DATA, REQ_VALID, REQ_LAST, TX_IDLE,
                  input  REQ_ACK, GRANT, TX_DATA, TX_DATA_READY, BUSY);
  modport slave  (input  REQ_DATA, REQ_VALID, REQ_LAST, TX_IDLE,
                  output REQ_ACK, GRANT, TX_DATA, TX_DATA_READY, BUSY);
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick of the first valid requester at or after the pointer
module rr_pick #(parameter int N = 4) (
  input  logic [$clog2(N)-1:0] i_ptr,
  input  logic [N-1:0]         i_valid,
  output logic [N-1:0]         o_grant
);
  // Scan from the farthest candidate back to the pointer so the nearest valid one wins
  always_comb begin
    int w;
    o_grant = '0;
    w = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w = int'(i_ptr) + k;
      w = w >= N ? w - N : w;
      if (i_valid[w]) begin
        o_grant = '0;
        o_grant[w] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter feeding uart_send; UART_ARB_TAG_EN prefixes each packet with TAG_BASE|owner
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         NREQ     = 4,
  parameter logic [7:0] TAG_BASE = TAG_BASE_DEF
) (
  input logic              CLK,
  input logic              RST,
  uart_tx_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  state_t            r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_gidx;
  logic [PW-1:0]     w_pick_idx;
  logic [NREQ-1:0]   r_grant;
  logic [NREQ-1:0]   r_ack;
  logic [NREQ-1:0]   w_pick;
  logic [7:0]        r_tx_data;
  logic              r_tx_rdy;
  logic              r_last;

  rr_pick #(.N(NREQ)) u_pick (.i_ptr(r_ptr), .i_valid(bus.REQ_VALID), .o_grant(w_pick));

  // One-hot pick converted to an index for data/last selection
  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NREQ; i++) if (w_pick[i]) w_pick_idx = PW'(i);
  end

  // Packet FSM: grant, load each byte when uart_send is idle, follow its busy period, release on last
  always_ff @(posedge CLK) begin
    r_tx_rdy <= 1'b0;
    r_ack    <= '0;
    if (RST) begin
      r_state   <= ST_ARB;
      r_ptr     <= '0;
      r_gidx    <= '0;
      r_grant   <= '0;
      r_tx_data <= 8'h00;
      r_last    <= 1'b0;
    end else begin
      case (r_state)
        ST_ARB: if (|bus.REQ_VALID) begin
          r_grant <= w_pick;
          r_gidx  <= w_pick_idx;
`ifdef UART_ARB_TAG_EN
          r_state <= ST_TAG;
`else
          r_state <= ST_LOAD;
`endif
        end
`ifdef UART_ARB_TAG_EN
        ST_TAG: if (bus.TX_IDLE) begin
          r_tx_data <= TAG_BASE | 8'(r_gidx);
          r_tx_rdy  <= 1'b1;
          r_last    <= 1'b0;
          r_state   <= ST_WAIT_BUSY;
        end
`endif
        ST_LOAD: if (bus.TX_IDLE && bus.REQ_VALID[r_gidx]) begin
          r_tx_data <= bus.REQ_DATA[{r_gidx, 3'b000} +: 8];
          r_tx_rdy  <= 1'b1;
          r_ack     <= r_grant;
          r_last    <= bus.REQ_LAST[r_gidx];
          r_state   <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: if (!bus.TX_IDLE) r_state <= ST_WAIT_IDLE;
        ST_WAIT_IDLE: if (bus.TX_IDLE) begin
          if (r_last) begin
            r_state <= ST_ARB;
            r_grant <= '0;
            r_ptr   <= r_gidx == PW'(NREQ - 1) ? '0 : r_gidx + 1'b1;
            r_last  <= 1'b0;
          end else r_state <= ST_LOAD;
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

  assign bus.REQ_ACK       = r_ack;
  assign bus.GRANT         = r_grant;
  assign bus.TX_DATA       = r_tx_data;
  assign bus.TX_DATA_READY = r_tx_rdy;
  assign bus.BUSY          = r_state != ST_ARB;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table vectors, corner sequences and randomized packets against a round-robin packet model
module tb_uart_tx_arbiter;
  localparam int N = 4;
`ifdef UART_ARB_TAG_EN
  localparam bit TAG_ON = 1'b1;
`else
  localparam bit TAG_ON = 1'b0;
`endif
  typedef struct { logic [7:0] d; bit last; } beat_t;
  typedef struct { logic [7:0] f; int n; } pk_t;
  typedef struct { logic [N-1:0] mask; logic [7:0] base; int owner; logic [7:0] exp_byte; } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(N)) bus ();
  uart_tx_arbiter #(.NREQ(N), .TAG_BASE(8'hA0)) dut (.CLK(clk), .RST(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  beat_t q [N][$];
  pk_t mq [N][$];
  logic [N-1:0] hold = '0;
  logic [7:0] txlog[$];
  logic [7:0] exp_tx[$];
  int acklog[$];
  int exp_ack[$];
  int grantlog[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out", nm);
  endtask

  function automatic int oh_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // uart_send model: a load while idle starts 10 bit times of 10 clocks each
  int u_div = 0;
  int u_bits = 0;
  bit u_busy = 1'b0;
  always @(posedge clk) begin
    u_div <= u_div == 9 ? 0 : u_div + 1;
    if (!u_busy && bus.TX_DATA_READY === 1'b1) begin
      u_busy <= 1'b1;
      u_bits <= 0;
    end else if (u_busy && u_div == 9) begin
      if (u_bits == 9) u_busy <= 1'b0;
      else u_bits <= u_bits + 1;
    end
  end
  assign bus.TX_IDLE = !u_busy;

  // Requester model: each requester presents the head of its beat queue, popped on its ACK
  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (bus.REQ_ACK[i] === 1'b1 && q[i].size() > 0) void'(q[i].pop_front());
      bus.REQ_VALID[i] = q[i].size() > 0 && !hold[i];
      bus.REQ_LAST[i] = q[i].size() > 0 ? q[i][0].last : 1'b0;
      bus.REQ_DATA[i*8 +: 8] = q[i].size() > 0 ? q[i][0].d : 8'h00;
    end
  end

  // Monitor: log strobes, acks and new grants; check strobe legality and ack one-hotness
  int since = 100;
  logic [N-1:0] g_prev = '0;
  always @(negedge clk) begin
    since++;
    if (bus.TX_DATA_READY === 1'b1) begin
      chk("strobe_spacing", since >= 3, 1);
      chk("strobe_uart_idle", u_busy, 0);
      since = 0;
      txlog.push_back(bus.TX_DATA);
    end
    if (|bus.REQ_ACK) begin
      chk("ack_onehot", $countones(bus.REQ_ACK), 1);
      acklog.push_back(oh_idx(bus.REQ_ACK));
    end
    if (bus.GRANT != 0 && g_prev == 0) grantlog.push_back(oh_idx(bus.GRANT));
    g_prev = bus.GRANT;
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pkt(int r, logic [7:0] f, int n);
    for (int k = 0; k < n; k++) q[r].push_back('{f + 8'(k), k == n - 1});
  endtask

  task automatic exp_pkt(int r, logic [7:0] f, int n);
    if (TAG_ON) exp_tx.push_back(8'hA0 | 8'(r));
    for (int k = 0; k < n; k++) begin
      exp_tx.push_back(f + 8'(k));
      exp_ack.push_back(r);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      mq[i].delete();
    end
    hold = '0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    for (int c = 0; c < 3000 && u_busy; c++) @(negedge clk);
    if (u_busy) timeout("reset_uart_idle");
    txlog.delete(); acklog.delete(); grantlog.delete();
    exp_tx.delete(); exp_ack.delete();
  endtask

  task automatic wait_ack(output int who);
    who = -1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (|bus.REQ_ACK) begin
        who = oh_idx(bus.REQ_ACK);
        return;
      end
    end
    timeout("wait_ack");
  endtask

  task automatic wait_acks(int n);
    for (int c = 0; c < 30000; c++) begin
      if (acklog.size() >= n) return;
      @(negedge clk);
    end
    timeout("wait_acks");
  endtask

  task automatic wait_done();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!bus.BUSY) return;
    end
    timeout("wait_done");
  endtask

  task automatic cmp_logs(string nm);
    chk({nm, "_nack"}, acklog.size(), exp_ack.size());
    for (int i = 0; i < acklog.size() && i < exp_ack.size(); i++) chk({nm, "_ack"}, acklog[i], exp_ack[i]);
    chk({nm, "_ntx"}, txlog.size(), exp_tx.size());
    for (int i = 0; i < txlog.size() && i < exp_tx.size(); i++) chk({nm, "_tx"}, txlog[i], exp_tx[i]);
  endtask

  task automatic chk_reset_outs(string nm);
    chk({nm, "_grant"}, bus.GRANT, 0);
    chk({nm, "_ack"}, bus.REQ_ACK, 0);
    chk({nm, "_txdata"}, bus.TX_DATA, 8'h00);
    chk({nm, "_rdy"}, bus.TX_DATA_READY, 0);
    chk({nm, "_busy"}, bus.BUSY, 0);
  endtask

  vec_t tbl[9];

  initial begin
    int who;
    int n0;
    int bad;
    tbl[0] = '{4'b0010, 8'hA9, 1, 8'hAA};
    tbl[1] = '{4'b1111, 8'h10, 2, 8'h12};
    tbl[2] = '{4'b0011, 8'h20, 0, 8'h20};
    tbl[3] = '{4'b1001, 8'h30, 3, 8'h33};
    tbl[4] = '{4'b1000, 8'h40, 3, 8'h43};
    tbl[5] = '{4'b0110, 8'h50, 1, 8'h51};
    tbl[6] = '{4'b0100, 8'h60, 2, 8'h62};
    tbl[7] = '{4'b1111, 8'h70, 3, 8'h73};
    tbl[8] = '{4'b1111, 8'h80, 0, 8'h80};

    cyc(3);
    chk_reset_outs("reset");
    rst = 1'b0;
    cyc(2);

    // Single-byte packets from a set of requesters; the pointer carries across vectors
    foreach (tbl[v]) begin
      txlog.delete(); acklog.delete();
      for (int i = 0; i < N; i++) if (tbl[v].mask[i]) q[i].push_back('{tbl[v].base + 8'(i), 1'b1});
      wait_ack(who);
      for (int i = 0; i < N; i++) q[i].delete();
      chk("tbl_owner", who, tbl[v].owner);
      chk("tbl_grant_at_ack", bus.GRANT, 1 << tbl[v].owner);
      wait_done();
      cyc(2);
      chk("tbl_byte", bus.TX_DATA, tbl[v].exp_byte);
      chk("tbl_grant_clear", bus.GRANT, 0);
      chk("tbl_strobes", txlog.size(), 1 + TAG_ON);
      chk("tbl_acks", acklog.size(), 1);
    end

    // Two 3-byte packets: requester 0 finishes before requester 2 starts
    do_reset();
    send_pkt(0, 8'h01, 3); send_pkt(2, 8'h21, 3);
    exp_pkt(0, 8'h01, 3); exp_pkt(2, 8'h21, 3);
    wait_acks(6);
    wait_done();
    cmp_logs("nopreempt");

    // All requesters repeatedly valid: grants rotate 0,1,2,3,0,...
    do_reset();
    for (int k = 0; k < 2; k++) for (int i = 0; i < N; i++) send_pkt(i, 8'(16 * i + k), 1);
    wait_acks(8);
    wait_done();
    chk("rotate_n", grantlog.size(), 8);
    for (int k = 0; k < grantlog.size() && k < 8; k++) chk("rotate_order", grantlog[k], k % N);

    // Owner drops VALID mid-packet: grant held, no strobe, then resumes
    do_reset();
    send_pkt(0, 8'h41, 3); send_pkt(1, 8'h51, 1);
    exp_pkt(0, 8'h41, 3); exp_pkt(1, 8'h51, 1);
    wait_ack(who);
    hold[0] = 1'b1;
    chk("hold_first_owner", who, 0);
    for (int c = 0; c < 3000 && !u_busy; c++) @(negedge clk);
    for (int c = 0; c < 3000 && u_busy; c++) @(negedge clk);
    if (u_busy) timeout("hold_uart_idle");
    n0 = txlog.size();
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.GRANT !== 4'b0001 || bus.BUSY !== 1'b1) bad++;
    end
    chk("hold_grant_kept", bad, 0);
    chk("hold_no_strobe", txlog.size(), n0);
    hold[0] = 1'b0;
    wait_acks(4);
    wait_done();
    cmp_logs("hold");

    // Reset while waiting for uart_send to finish a byte
    do_reset();
    send_pkt(0, 8'h61, 2);
    wait_ack(who);
    for (int c = 0; c < 3000 && !u_busy; c++) @(negedge clk);
    cyc(5);
    chk("midreset_busy_before", bus.BUSY, 1);
    for (int i = 0; i < N; i++) q[i].delete();
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("midreset");
    rst = 1'b0;
    n0 = txlog.size();
    cyc(300);
    chk("midreset_no_strobe", txlog.size(), n0);

    // Randomized packets, all queued up front, against a round-robin packet model
    for (int rd = 0; rd < 3; rd++) begin
      int ptr;
      int total;
      do_reset();
      for (int r = 0; r < N; r++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int k = 0; k < np; k++) begin
          pk_t p;
          p.f = 8'($urandom);
          p.n = $urandom_range(1, 3);
          send_pkt(r, p.f, p.n);
          mq[r].push_back(p);
        end
      end
      ptr = 0;
      total = 0;
      forever begin
        int pick;
        pk_t p;
        pick = -1;
        for (int k = 0; k < N; k++) if (pick < 0 && mq[(ptr + k) % N].size() > 0) pick = (ptr + k) % N;
        if (pick < 0) break;
        p = mq[pick].pop_front();
        exp_pkt(pick, p.f, p.n);
        total += p.n;
        ptr = (pick + 1) % N;
      end
      wait_acks(total);
      wait_done();
      cyc(2);
      cmp_logs("random");
      chk("random_grant_clear", bus.GRANT, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
